// File: rtl/adc_scan_pkg.sv
// Shared types for the multi-channel ADC scan reader: FSM states and channel-width helper.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_DRDY,
        ST_SHIFT,
        ST_STORE,
        ST_NEXT
    } state_e;

    // A single-channel build still needs a 1-bit mux select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI frame reader: generates SCLK, drops leading status bits, shifts data in MSB first.
// done is combinational on the final SCLK fall so the caller can leave SHIFT on that same edge.
module adc_spi_shifter #(
    parameter int DATA_W    = 24,
    parameter int PRE_BITS  = 1,
    parameter int SCLK_HALF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              dout,
    output logic              sclk,
    output logic              done,
    output logic [DATA_W-1:0] data
);

    localparam int TOTAL = PRE_BITS + DATA_W;
    localparam int HC_W  = $clog2(SCLK_HALF);
    localparam int BC_W  = $clog2(TOTAL + 1);

    logic              active_q, active_d;
    logic              sclk_q, sclk_d;
    logic [HC_W-1:0]   half_q, half_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              half_end;

    assign half_end = active_q && (half_q == HC_W'(SCLK_HALF - 1));
    assign done     = half_end && sclk_q && (bit_q == BC_W'(TOTAL - 1));
    assign sclk     = sclk_q;
    assign data     = sreg_q;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        half_d   = half_q;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        if (go) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            half_d   = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (half_end) begin
                half_d = '0;
                sclk_d = ~sclk_q;
                // Capture on the rising SCLK edge; fall advances the bit count.
                if (!sclk_q) begin
                    if (bit_q >= BC_W'(PRE_BITS)) begin
                        sreg_d = {sreg_q[DATA_W-2:0], dout};
                    end
                end else if (done) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                half_d = half_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            half_q   <= '0;
            bit_q    <= '0;
            sreg_q   <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            sreg_q   <= sreg_d;
        end
    end

endmodule

// File: rtl/adc_mux_scan_reader.sv
// Scans N_CH mux inputs of a serial ADC per sync edge (or continuously), tagging each sample
// with its channel on a valid/ready output; sticky flags report timeout, overrun and stray syncs.
module adc_mux_scan_reader
    import adc_scan_pkg::*;
#(
    parameter int  DATA_W    = 24,
    parameter int  PRE_BITS  = 1,
    parameter int  N_CH      = 4,
    parameter int  SCLK_HALF = 4,
    parameter int  SETTLE    = 16,
    parameter int  DRDY_TO   = 65535,
    parameter int  RST_CYC   = 32,
    localparam int CH_W      = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              cont_mode,
    input  logic              clr_err,
    input  logic              drdy,
    input  logic              dout,
    output logic              sclk,
    output logic              cs_n,
    output logic              start,
    output logic              adc_rst_n,
    output logic [CH_W-1:0]   a_mux,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              err_sync
);

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              start_q, start_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              err_to_q, err_to_d;
    logic              err_ov_q, err_ov_d;
    logic              err_sy_q, err_sy_d;
    logic              sync_q;
    logic              drdy_meta_q, drdy_sync_q, drdy_prev_q;
    logic              sync_rise, drdy_rise, shift_go, sh_done;
    logic [DATA_W-1:0] sh_data;

    assign sync_rise = sync & ~sync_q;
    assign drdy_rise = drdy_sync_q & ~drdy_prev_q;

    adc_spi_shifter #(
        .DATA_W   (DATA_W),
        .PRE_BITS (PRE_BITS),
        .SCLK_HALF(SCLK_HALF)
    ) u_shifter (
        .clk (clk),
        .rst (rst),
        .go  (shift_go),
        .dout(dout),
        .sclk(sclk),
        .done(sh_done),
        .data(sh_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        start_d     = 1'b0;
        shift_go    = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        err_to_d    = clr_err ? 1'b0 : err_to_q;
        err_ov_d    = clr_err ? 1'b0 : err_ov_q;
        err_sy_d    = clr_err ? 1'b0 : err_sy_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (sync_rise && busy) begin
            err_sy_d = 1'b1;
        end

        case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q == 32'(RST_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_IDLE: begin
                if (sync_rise) begin
                    ch_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 32'(SETTLE - 1)) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_DRDY;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WAIT_DRDY: begin
                if (drdy_rise) begin
                    shift_go = 1'b1;
                    state_d  = ST_SHIFT;
                end else if (cnt_q == 32'(DRDY_TO - 1)) begin
                    err_to_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                // A sample leaving this cycle frees the register for the new one.
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sh_data;
                    out_ch_d    = ch_q;
                end else begin
                    err_ov_d = 1'b1;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                cnt_d = '0;
                if (ch_q != CH_W'(N_CH - 1)) begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_SETUP;
                end else if (cont_mode) begin
                    ch_d    = '0;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= '0;
            ch_q        <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            err_sy_q    <= 1'b0;
            sync_q      <= 1'b0;
            drdy_meta_q <= 1'b0;
            drdy_sync_q <= 1'b0;
            drdy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
            err_sy_q    <= err_sy_d;
            sync_q      <= sync;
            drdy_meta_q <= drdy;
            drdy_sync_q <= drdy_meta_q;
            drdy_prev_q <= drdy_sync_q;
        end
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_RST_HOLD);
    assign cs_n        = (state_q != ST_SHIFT);
    assign adc_rst_n   = (state_q != ST_RST_HOLD);
    assign start       = start_q;
    assign a_mux       = ch_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;
    assign err_sync    = err_sy_q;

endmodule

// File: tb/tb_adc_mux_scan_reader.sv
// Bench for adc_mux_scan_reader: behavioural ADC model, sample monitor, directed scans.
module tb_adc_mux_scan_reader;

    localparam int DATA_W = 24;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } sample_t;

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              stat;
        logic [CH_W-1:0]   exp_ch;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst, sync, cont_mode, clr_err, drdy, dout, out_ready;
    logic sclk, cs_n, start, adc_rst_n, out_valid, busy;
    logic err_timeout, err_overrun, err_sync;
    logic [CH_W-1:0]   a_mux, out_ch;
    logic [DATA_W-1:0] out_data;

    logic [DATA_W-1:0] adc_word [4];
    logic              adc_stat [4];
    logic              drdy_block [4];
    sample_t           got_q [$];
    int                sclk_rises = 0;
    int                tests = 0;
    int                fails = 0;

    adc_mux_scan_reader dut (
        .clk(clk), .rst(rst), .sync(sync), .cont_mode(cont_mode), .clr_err(clr_err),
        .drdy(drdy), .dout(dout), .sclk(sclk), .cs_n(cs_n), .start(start),
        .adc_rst_n(adc_rst_n), .a_mux(a_mux), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // ADC: raise DRDY a few clocks after START, present the frame MSB first, next bit after each SCLK fall.
    initial begin
        logic [CH_W-1:0]   c;
        logic [DATA_W:0]   frame;
        drdy = 1'b0;
        dout = 1'b0;
        forever begin
            @(posedge start);
            c = a_mux;
            repeat (4) @(posedge clk);
            #1;
            if (!drdy_block[c]) begin
                frame = {adc_stat[c], adc_word[c]};
                drdy  = 1'b1;
                @(negedge cs_n);
                drdy = 1'b0;
                dout = frame[DATA_W];
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    @(negedge sclk);
                    dout = frame[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({out_ch, out_data});
    end

    always @(posedge sclk) sclk_rises++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic sample_t get_sample(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return {2'b00, 24'hBADBAD};
    endfunction

    task automatic pulse_sync();
        @(posedge clk); #1 sync = 1'b1;
        @(posedge clk); #1 sync = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    vec_t vt [4];

    initial begin
        int      base, n, sb, lat;
        sample_t s;
        logic [CH_W-1:0] cont_exp [8];

        vt[0] = '{24'h123456, 1'b1, 2'd0, 24'h123456};
        vt[1] = '{24'h800000, 1'b0, 2'd1, 24'h800000};
        vt[2] = '{24'h7FFFFF, 1'b1, 2'd2, 24'h7FFFFF};
        vt[3] = '{24'h000001, 1'b1, 2'd3, 24'h000001};
        cont_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            adc_word[i]   = vt[i].word;
            adc_stat[i]   = vt[i].stat;
            drdy_block[i] = 1'b0;
        end

        rst = 1'b1; sync = 1'b0; cont_mode = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and ADC reset hold length
        @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_start", 32'(start), 32'd0);
        check("rst_a_mux", 32'(a_mux), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", {29'd0, err_timeout, err_overrun, err_sync}, 32'd0);
        n = 0;
        while (!adc_rst_n && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("adc_rst_n_low_cycles", 32'(n), 32'd32);

        // Single scan: table-driven data, start latency, SCLK pulse count
        base = got_q.size();
        sb   = sclk_rises;
        @(posedge clk); #1 sync = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!start && lat < 100);
        check("sync_to_start", 32'(lat), 32'd17);
        sync = 1'b0;
        wait_idle("scan1_done", 5000);
        check("scan1_count", 32'(got_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            s = get_sample(base + i);
            check($sformatf("scan1_ch[%0d]", i), 32'(s.ch), 32'(vt[i].exp_ch));
            check($sformatf("scan1_data[%0d]", i), 32'(s.data), 32'(vt[i].exp_data));
        end
        check("scan1_sclk_pulses", 32'(sclk_rises - sb), 32'd100);
        check("scan1_no_errs", {29'd0, err_timeout, err_overrun, err_sync}, 32'd0);

        // Continuous mode, cleared during the second pass
        adc_word[0] = 24'hA5A5A5; adc_word[1] = 24'h5A5A5A;
        adc_word[2] = 24'hFFFFFF; adc_word[3] = 24'h000000;
        base = got_q.size();
        cont_mode = 1'b1;
        pulse_sync();
        n = 0;
        while (got_q.size() - base < 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        cont_mode = 1'b0;
        wait_idle("cont_done", 5000);
        check("cont_count", 32'(got_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            s = get_sample(base + i);
            check($sformatf("cont_ch[%0d]", i), 32'(s.ch), 32'(cont_exp[i]));
            check($sformatf("cont_data[%0d]", i), 32'(s.data), 32'(adc_word[cont_exp[i]]));
        end

        // DRDY timeout on ch1
        for (int i = 0; i < 4; i++) adc_word[i] = vt[i].word;
        drdy_block[1] = 1'b1;
        base = got_q.size();
        pulse_sync();
        n = 0;
        while (!(start && a_mux == 2'd1) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        lat = 0;
        while (!err_timeout && lat < 70000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("timeout_cycles", 32'(lat), 32'd65535);
        wait_idle("timeout_done", 5000);
        drdy_block[1] = 1'b0;
        check("timeout_flag", 32'(err_timeout), 32'd1);
        check("timeout_count", 32'(got_q.size() - base), 32'd3);
        s = get_sample(base);     check("timeout_s0", 32'(s), 32'({2'd0, 24'h123456}));
        s = get_sample(base + 1); check("timeout_s1", 32'(s), 32'({2'd2, 24'h7FFFFF}));
        s = get_sample(base + 2); check("timeout_s2", 32'(s), 32'({2'd3, 24'h000001}));
        pulse_clr();
        @(negedge clk);
        check("timeout_cleared", 32'(err_timeout), 32'd0);

        // Overrun: consumer stalled for the whole scan
        base = got_q.size();
        out_ready = 1'b0;
        pulse_sync();
        wait_idle("overrun_done", 5000);
        check("overrun_flag", 32'(err_overrun), 32'd1);
        check("overrun_valid", 32'(out_valid), 32'd1);
        check("overrun_held", 32'({out_ch, out_data}), 32'({2'd0, 24'h123456}));
        pulse_clr();
        @(negedge clk);
        check("overrun_cleared", 32'(err_overrun), 32'd0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("overrun_drain_count", 32'(got_q.size() - base), 32'd1);
        check("overrun_drain_valid", 32'(out_valid), 32'd0);

        // Stray sync during SHIFT, then reset mid-frame
        base = got_q.size();
        pulse_sync();
        n = 0;
        while (cs_n && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_shift", 32'(cs_n), 32'd0);
        repeat (40) @(posedge clk);
        pulse_sync();
        @(negedge clk);
        check("abort_err_sync", 32'(err_sync), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_err_sync_rst", 32'(err_sync), 32'd0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("abort_no_partial", 32'(n + got_q.size() - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_mux_scan_reader.md
Name: adc_mux_scan_reader

Overview:
Parametrised successor of the single-channel ADC045 reader. On a sync pulse it scans N_CH analog-mux inputs in order. For each channel it drives a_mux, issues a START pulse, waits for DRDY and shifts in a PRE_BITS+DATA_W frame over SPI (SCLK/DOUT). Samples are delivered upstream, tagged with their channel, through a valid/ready handshake. It adds continuous-scan mode, DRDY timeout, overrun detection and sticky error flags.

Parameters:
DATA_W, 24, sample width; MSB first on DOUT.
PRE_BITS, 1, leading status bits clocked out and discarded before data.
N_CH, 4, mux channels scanned (1..16); CH_W = max(1, $clog2(N_CH)).
SCLK_HALF, 4, clk cycles per SCLK half-period (>=2).
SETTLE, 16, clk cycles between a_mux change and START pulse.
DRDY_TO, 65535, clk cycles waited for DRDY before timeout.
RST_CYC, 32, clk cycles adc_rst_n is held low after rst.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sync  in  1  scan trigger; rising edge detected internally
cont_mode  in  1  1 = restart scan automatically after channel N_CH-1
clr_err  in  1  clears sticky error flags
drdy  in  1  ADC data-ready, asynchronous; 2-FF synchronised
dout  in  1  ADC serial data, sampled at SCLK rise
sclk  out  1  SPI clock, idle low
cs_n  out  1  ADC chip select, low during SHIFT only
start  out  1  one-clk conversion-start pulse
adc_rst_n  out  1  ADC reset, active low
a_mux  out  CH_W  current mux channel
out_data  out  DATA_W  sample; valid while out_valid
out_ch  out  CH_W  channel tag of out_data
out_valid  out  1  sample available
out_ready  in  1  consumer accepts when valid&ready
busy  out  1  high in any state except IDLE and RST_HOLD
err_timeout, err_overrun, err_sync  out  1 each  sticky error flags

Behaviour:
- Reset (rst=1 at a clk edge): state RST_HOLD. adc_rst_n=0, sclk=0, cs_n=1, start=0, a_mux=0, out_valid=0, out_data=0, out_ch=0, busy=0, all error flags=0. rst mid-operation aborts the frame immediately; any partial sample is discarded.
- RST_HOLD: hold for RST_CYC cycles, then adc_rst_n=1 and go to IDLE.
- IDLE: on sync rising edge, ch=0 and go to SETUP. A sync level held high does not retrigger.
- SETUP: a_mux=ch; after SETTLE cycles pulse start for 1 clk, then go to WAIT_DRDY.
- WAIT_DRDY: on a synchronised drdy rising edge (3 clk after the pin edge), cs_n=0 and go to SHIFT. If DRDY_TO cycles elapse first, set err_timeout, emit no sample for this channel, and go to NEXT.
- SHIFT: emit PRE_BITS+DATA_W SCLK pulses, each SCLK_HALF clk low then SCLK_HALF clk high. dout is captured on the clk edge where sclk goes 0->1. The first PRE_BITS captures are dropped; the remaining bits fill the shift register MSB first. After the last high phase: sclk=0, cs_n=1, go to STORE.
- STORE (1 clk): if out_valid=0, or the current sample is being accepted this cycle, load out_data/out_ch and set out_valid=1. Otherwise set err_overrun and drop the new sample; the held sample is kept.
- out_valid clears on the cycle after valid&ready unless STORE reloads in the same cycle.
- NEXT: if ch<N_CH-1, ch+1 -> SETUP. If ch=N_CH-1: with cont_mode=1, ch=0 -> SETUP; otherwise go to IDLE.
- sync rising edge in any busy state: ignored, sets err_sync.
- clr_err clears all flags. If a flag's set condition occurs in the same cycle, set wins.
- Latency: sync edge to first start pulse = SETTLE+1 clk. SHIFT length = 2*SCLK_HALF*(PRE_BITS+DATA_W) clk.

Decomposition:
- Package adc_scan_pkg: state enum (RST_HOLD, IDLE, SETUP, WAIT_DRDY, SHIFT, STORE, NEXT) and a CH_W helper function.
- One sub-module, adc_spi_shifter: SCLK generation, bit counter, PRE_BITS drop, and DATA_W capture, with go/done handshake.
- The FSM, timeout counter, output register and error logic stay in the top.

Test Plan:
- Reset release -> adc_rst_n low for exactly 32 clk, all outputs at reset values, busy=0.
- One sync, cont_mode=0, ADC model returns 0x123456, 0x800000, 0x7FFFFF, 0x000001 on ch0..3 with out_ready=1 -> four out_valid pulses with matching data and out_ch=0..3 in order, then IDLE, busy=0.
- cont_mode=1 -> ch0 of the second scan follows ch3 with no sync; clearing cont_mode mid-scan ends after ch3.
- No DRDY on ch1 -> err_timeout=1 after 65535 clk; samples only for ch0, ch2, ch3.
- out_ready=0 through the scan -> ch0 sample held, err_overrun=1, ch1..3 dropped; clr_err clears the flag.
- sync pulse during SHIFT, then rst asserted mid-SHIFT -> err_sync=1 before reset; after reset sclk=0, cs_n=1, out_valid=0, no partial sample emitted.
